// File: rtl/instr_fetch_controller.sv
// Fetch sequencer for the RV32 pipeline: owns the fetch PC, drives one word read per cycle into a
// synchronous-read instruction memory, and hands (instruction, PC) pairs to decode.
module instr_fetch_controller #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumEntries = 31,
    localparam int unsigned AddrWidth = $clog2(NumEntries),
    parameter logic [31:0] ResetPc    = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 fetch_en_i,
    input  logic                 redirect_valid_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 imem_rd_valid_o,
    output logic [AddrWidth-1:0] imem_rd_addr_o,
    input  logic [DataWidth-1:0] imem_rd_data_i,
    output logic                 instr_valid_o,
    output logic [DataWidth-1:0] instr_o,
    output logic [31:0]          instr_pc_o,
    input  logic                 decode_ready_i,
    output logic                 fetch_fault_o,
    output logic [31:0]          fetch_count_o,
    output logic                 dbg_state_o
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

    localparam logic [31:0] NumEntriesW = 32'(NumEntries);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_q;
    logic        pc_ok;
    logic        issue;
    logic        accept;
    logic        fault_set;

    // Decode handshake: instr_valid_o/instr_o/instr_pc_o stay stable until a cycle where
    // instr_valid_o & decode_ready_i are both high; that cycle is the transfer (accept).
    assign accept = instr_valid_o & decode_ready_i;

    // A word index below NumEntries also guarantees pc[31:AddrWidth+2] is zero.
    assign pc_ok = ((pc_q >> 2) < NumEntriesW) && (pc_q[1:0] == 2'b00);

    assign imem_rd_valid_o = issue;
    assign imem_rd_addr_o  = pc_q[AddrWidth+1:2];
    assign instr_o         = imem_rd_data_i;
    assign dbg_state_o     = state_q;

    always_comb begin
        state_d   = state_q;
        fault_set = 1'b0;
        issue     = 1'b0;
        if (!reset_i && state_q == ST_FETCH) begin
            if (redirect_valid_i) begin
                if (redirect_pc_i[1:0] != 2'b00) begin
                    state_d   = ST_HALT;
                    fault_set = 1'b1;
                end
            end else if (!pc_ok) begin
                state_d   = ST_HALT;
                fault_set = 1'b1;
            end else if (fetch_en_i && (!instr_valid_o || decode_ready_i)) begin
                issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_FETCH;
            pc_q          <= ResetPc;
            instr_valid_o <= 1'b0;
            instr_pc_o    <= 32'h0;
            fetch_fault_o <= 1'b0;
            fetch_count_o <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_fault_o <= fetch_fault_o | fault_set;
            if (accept) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            // Redirect flushes whatever is presented; the accept above still counts.
            if (redirect_valid_i) begin
                pc_q          <= redirect_pc_i;
                instr_valid_o <= 1'b0;
            end else if (issue) begin
                pc_q          <= pc_q + 32'd4;
                instr_valid_o <= 1'b1;
                instr_pc_o    <= pc_q;
            end else if (accept) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_controller.sv
// Directed bench for instr_fetch_controller: cycle-exact point checks from the stimulus thread and
// an accept-side scoreboard that pairs every decode transfer with the expected (pc, instruction).
module tb_instr_fetch_controller;

    localparam int DW = 32;
    localparam int NE = 31;
    localparam int AW = $clog2(NE);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          fetch_en_i;
    logic          redirect_valid_i;
    logic [31:0]   redirect_pc_i;
    logic          imem_rd_valid_o;
    logic [AW-1:0] imem_rd_addr_o;
    logic [DW-1:0] imem_rd_data_i = '0;
    logic          instr_valid_o;
    logic [DW-1:0] instr_o;
    logic [31:0]   instr_pc_o;
    logic          decode_ready_i;
    logic          fetch_fault_o;
    logic [31:0]   fetch_count_o;
    logic          dbg_state_o;

    logic [DW-1:0] mem [0:NE-1];
    logic [63:0]   exp_q [$];
    logic [63:0]   exp_e;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_controller #(.DataWidth(DW), .NumEntries(NE), .ResetPc(32'h0)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fetch_en_i       (fetch_en_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_rd_valid_o  (imem_rd_valid_o),
        .imem_rd_addr_o   (imem_rd_addr_o),
        .imem_rd_data_i   (imem_rd_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .decode_ready_i   (decode_ready_i),
        .fetch_fault_o    (fetch_fault_o),
        .fetch_count_o    (fetch_count_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Memory model: word i holds A500_0000 | byte address, so the expected word follows from the pc.
    initial for (int i = 0; i < NE; i++) mem[i] = 32'hA500_0000 | 32'(i * 4);

    always @(posedge clk) if (imem_rd_valid_o) imem_rd_data_i <= mem[imem_rd_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, 32'hA500_0000 | pc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor: sampled mid-cycle, compares every decode transfer.
    always @(negedge clk) begin
        if (!reset_i && instr_valid_o && decode_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_accept: got pc %h expected none", instr_pc_o);
            end else begin
                exp_e = exp_q.pop_front();
                check("accept_pc", instr_pc_o, exp_e[63:32]);
                check("accept_instr", instr_o, exp_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i          = 1'b1;
        fetch_en_i       = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        decode_ready_i   = 1'b1;

        // Reset state
        tick(); settle();
        check("rst_rd_valid", 32'(imem_rd_valid_o), 32'd0);
        check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_fault", 32'(fetch_fault_o), 32'd0);
        check("rst_count", fetch_count_o, 32'd0);

        // Free run
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        reset_i = 1'b0; settle();
        check("run_addr0", 32'(imem_rd_addr_o), 32'd0);
        check("run_rd_valid0", 32'(imem_rd_valid_o), 32'd1);
        tick(); settle();
        check("run_addr1", 32'(imem_rd_addr_o), 32'd1);
        check("run_pc0", instr_pc_o, 32'h0);
        tick(); settle();
        check("run_addr2", 32'(imem_rd_addr_o), 32'd2);

        // Backpressure with instr_pc_o = 0x8
        tick(); decode_ready_i = 1'b0; settle();
        check("bp_count", fetch_count_o, 32'd2);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); settle(); end
            check("bp_rd_valid", 32'(imem_rd_valid_o), 32'd0);
            check("bp_valid", 32'(instr_valid_o), 32'd1);
            check("bp_pc", instr_pc_o, 32'h8);
            check("bp_instr", instr_o, 32'hA500_0008);
        end
        tick(); decode_ready_i = 1'b1; settle();
        check("bp_release_addr", 32'(imem_rd_addr_o), 32'd3);
        check("bp_release_rd", 32'(imem_rd_valid_o), 32'd1);

        // Redirect to 0x20 while pc = 0x10
        tick(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h20; settle();
        check("redir_presented_pc", instr_pc_o, 32'hC);
        check("redir_count3", fetch_count_o, 32'd3);
        check("redir_no_read", 32'(imem_rd_valid_o), 32'd0);
        push_exp(32'h20); push_exp(32'h24);
        tick(); redirect_valid_i = 1'b0; settle();
        check("redir_flush", 32'(instr_valid_o), 32'd0);
        check("redir_addr", 32'(imem_rd_addr_o), 32'd8);
        check("redir_rd_valid", 32'(imem_rd_valid_o), 32'd1);
        check("redir_count", fetch_count_o, 32'd4);
        tick(); settle();
        check("redir_target_pc", instr_pc_o, 32'h20);
        check("redir_addr9", 32'(imem_rd_addr_o), 32'd9);

        // Misaligned redirect
        tick(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h22; settle();
        check("mis_no_read", 32'(imem_rd_valid_o), 32'd0);
        check("mis_presented_pc", instr_pc_o, 32'h24);
        tick(); redirect_valid_i = 1'b0; settle();
        check("mis_fault", 32'(fetch_fault_o), 32'd1);
        check("mis_flush", 32'(instr_valid_o), 32'd0);
        check("mis_count", fetch_count_o, 32'd6);
        check("mis_state", 32'(dbg_state_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("halt_rd_valid", 32'(imem_rd_valid_o), 32'd0);
            check("halt_fault", 32'(fetch_fault_o), 32'd1);
        end

        // Reset mid-stream
        tick(); reset_i = 1'b1; settle();
        check("rst2_rd_valid", 32'(imem_rd_valid_o), 32'd0);
        push_exp(32'h0);
        tick(); reset_i = 1'b0; settle();
        check("rst2_addr0", 32'(imem_rd_addr_o), 32'd0);
        check("rst2_fault_clr", 32'(fetch_fault_o), 32'd0);
        tick(); settle();
        check("rst2_pc0", instr_pc_o, 32'h0);
        tick(); reset_i = 1'b1; decode_ready_i = 1'b0; settle();
        check("rst2_inflight", 32'(instr_valid_o), 32'd1);
        check("rst2_inflight_pc", instr_pc_o, 32'h4);
        check("rst2_rd_valid_in_rst", 32'(imem_rd_valid_o), 32'd0);
        tick(); reset_i = 1'b0; decode_ready_i = 1'b1;
        for (int k = 0; k < NE; k++) push_exp(32'(k * 4));
        settle();
        check("rst2_discard", 32'(instr_valid_o), 32'd0);
        check("rst2_count", fetch_count_o, 32'd0);
        check("rst2_state", 32'(dbg_state_o), 32'd0);

        // Sequential run to the end of memory
        for (int k = 0; k < NE; k++) begin
            if (k > 0) begin tick(); settle(); end
            check("end_addr", 32'(imem_rd_addr_o), 32'(k));
            check("end_rd_valid", 32'(imem_rd_valid_o), 32'd1);
        end
        tick(); settle();
        check("end_no_read", 32'(imem_rd_valid_o), 32'd0);
        check("end_last_valid", 32'(instr_valid_o), 32'd1);
        check("end_last_pc", instr_pc_o, 32'h78);
        tick(); settle();
        check("end_fault", 32'(fetch_fault_o), 32'd1);
        check("end_drained", 32'(instr_valid_o), 32'd0);
        check("end_count", fetch_count_o, 32'd31);
        check("end_rd_valid_off", 32'(imem_rd_valid_o), 32'd0);

        tick(); tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_controller.md
Name: instr_fetch_controller

Overview:
- Sequences the synchronous-read instruction memory for the pipelined RV32 core.
- Owns the fetch PC and issues one word read per cycle.
- Pairs each returned word with the PC that fetched it, and presents instruction and PC to decode through a valid/ready handshake.
- Handles decode backpressure, branch/jump redirects with flush, and out-of-range or misaligned fetch faults.

Parameters:
- DataWidth, 32, instruction word width; must match the instruction memory.
- NumEntries, 31, instruction memory depth in words.
- AddrWidth, $clog2(NumEntries), memory word-address width (derived, not overridden).
- ResetPc, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- fetch_en_i  in  1  global fetch enable; low blocks new reads (hazard stall).
- redirect_valid_i  in  1  branch/jump taken; flush and restart at redirect_pc_i.
- redirect_pc_i  in  32  byte PC of redirect target.
- imem_rd_valid_o  out  1  read strobe to instruction memory.
- imem_rd_addr_o  out  AddrWidth  word address to memory, equal to pc[AddrWidth+1:2].
- imem_rd_data_i  in  DataWidth  memory read data; 1-cycle latency; holds value while strobe is low.
- instr_valid_o  out  1  instr_o / instr_pc_o are valid for decode.
- instr_o  out  DataWidth  instruction to decode; combinational pass-through of imem_rd_data_i.
- instr_pc_o  out  32  byte PC of instr_o.
- decode_ready_i  in  1  decode accepts the instruction this cycle when instr_valid_o is high.
- fetch_fault_o  out  1  sticky; set on out-of-range or misaligned PC.
- fetch_count_o  out  32  count of instructions accepted by decode.

Behaviour:
- Reset values:
  - state = FETCH, pc = ResetPc.
  - instr_valid_o = 0, instr_pc_o = 0, fetch_fault_o = 0, fetch_count_o = 0.
  - imem_rd_valid_o = 0 during the reset cycle.
- State machine:
  - States: FETCH, HALT.
  - FETCH -> HALT when the PC about to issue is out of range, i.e. its word index ≥ NumEntries or pc[31:AddrWidth+2] ≠ 0.
  - FETCH -> HALT when redirect_pc_i[1:0] ≠ 0 on a redirect.
  - Either transition sets fetch_fault_o. No read is issued for the faulting PC.
  - HALT is left only by reset_i.
- Definitions:
  - accept = instr_valid_o & decode_ready_i.
  - issue = state==FETCH & fetch_en_i & ~redirect_valid_i & pc in range & (~instr_valid_o | decode_ready_i).
  - imem_rd_valid_o = issue (combinational); imem_rd_addr_o = pc[AddrWidth+1:2].
- On issue:
  - pc <= pc + 4.
  - Next cycle: instr_valid_o <= 1, instr_pc_o <= issued pc.
  - Fetch-to-valid latency is exactly 1 cycle; with decode_ready_i held high, throughput is 1 instruction/cycle.
- No issue and accept: instr_valid_o <= 0.
- No issue and no accept: instr_valid_o, instr_pc_o hold. The memory holds rd_data, so instr_o stays stable. The instruction is never dropped or duplicated.
- Redirect:
  - Has highest priority below reset.
  - pc <= redirect_pc_i and instr_valid_o <= 0 (flush).
  - No read in the redirect cycle.
  - The first target read issues the next cycle, giving a 1-cycle bubble.
  - A redirect in the same cycle as accept still counts the accepted instruction.
- HALT: no issues. A valid instruction already presented still drains normally on accept.
- fetch_count_o increments by 1 on each accept and wraps at 2^32. It is not cleared by redirect.
- fetch_en_i low: suppresses issue only. The presented instruction may still be accepted, after which instr_valid_o drops.
- Reset mid-stream: any in-flight instruction is discarded; fetch restarts at ResetPc the cycle after reset deasserts.
- pc + 4 arithmetic is 32-bit unsigned. Reaching the out-of-range limit is a fault, not a wrap.

Test Plan:
- Free run: reset, ResetPc=0, decode_ready_i=1, fetch_en_i=1 -> imem_rd_addr_o = 0,1,2,... on consecutive cycles; instr_pc_o = 0x0,0x4,0x8 one cycle later; fetch_count_o = 3 after 3 accepts.
- Backpressure: decode_ready_i=0 for 3 cycles while instr_pc_o=0x8 -> imem_rd_valid_o=0; instr_o and instr_pc_o stable for 3 cycles; on release, next instr_pc_o = 0xC; no skip or duplicate.
- Redirect: redirect_valid_i=1, redirect_pc_i=0x20 while pc=0x10 -> instr_valid_o=0 next cycle; next read address = 8; instr_pc_o=0x20 two cycles after the redirect.
- Misaligned redirect: redirect_pc_i=0x22 -> fetch_fault_o=1 and stays 1; imem_rd_valid_o stays 0 until reset.
- End of memory: NumEntries=31, sequential run -> last read at word 30 (pc 0x78); pc 0x7C does not issue; fetch_fault_o=1; word 30 is still delivered to decode.
- Reset mid-stream: assert reset_i with instr_valid_o=1 -> next cycle instr_valid_o=0 and fetch_count_o=0; the first read after deassert is at address 0.
